// File: rtl/ring_router_pkg.sv
// Shared packet-field positions, port indices and helpers for the ring router node.
package ring_router_pkg;

    // Packet bit positions; bit 0 is the MSB of the 64-bit packet
    localparam int unsigned PKT_W   = 64;
    localparam int unsigned VC_BIT  = 0;
    localparam int unsigned DIR_BIT = 1;
    localparam int unsigned HOP_MSB = 8;
    localparam int unsigned HOP_LSB = 15;

    typedef logic [0:PKT_W-1] pkt_t;

    // Link / arbiter request index
    typedef enum logic [1:0] {
        CW  = 2'd0,
        CCW = 2'd1,
        PE  = 2'd2
    } port_e;

    // Returns the packet with its hop count reduced by one; other fields untouched
    function automatic pkt_t hop_dec(input pkt_t pkt);
        pkt_t w_pkt;
        w_pkt                  = pkt;
        w_pkt[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] - 8'd1;
        return w_pkt;
    endfunction

    // Cyclic successor in arbitration order cw -> ccw -> pe -> cw
    function automatic port_e next_port(input port_e p);
        case (p)
            CW:      return CCW;
            CCW:     return PE;
            default: return CW;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-request round-robin arbiter; the granted requester drops to lowest priority.
module rr_arb3
    import ring_router_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [2:0] i_req,
    output logic [2:0] o_gnt
);

    port_e r_ptr;
    port_e w_ptr_nxt;
    port_e w_cand;
    logic  w_found;

    // Scan requests starting at the pointer; first hit wins when the output is free
    always_comb begin
        o_gnt     = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        w_cand    = r_ptr;
        for (int unsigned k = 0; k < 3; k++) begin
            if (i_en && !w_found && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                w_found       = 1'b1;
                w_ptr_nxt     = next_port(w_cand);
            end
            w_cand = next_port(w_cand);
        end
    end

    // Priority pointer: cw highest after reset, moves only on a grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= CW;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/ring_router_node.sv
// Three-port, two-VC bidirectional ring router node. Each cycle the VC equal to
// polarity moves input->output internally, while the other VC crosses the links.
module ring_router_node
    import ring_router_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        polarity,
    input  logic        cwsi,
    input  logic        ccwsi,
    input  logic        pesi,
    output logic        cwri,
    output logic        ccwri,
    output logic        peri,
    input  logic [0:63] cwdi,
    input  logic [0:63] ccwdi,
    input  logic [0:63] pedi,
    output logic        cwso,
    output logic        ccwso,
    output logic        peso,
    input  logic        cwro,
    input  logic        ccwro,
    input  logic        pero,
    output logic [0:63] cwdo,
    output logic [0:63] ccwdo,
    output logic [0:63] pedo
);

    logic       r_pol;
    logic [1:0] r_ib_full [3];
    pkt_t       r_ib_data [3][2];
    logic [1:0] r_ob_full [3];
    pkt_t       r_ob_data [3][2];

    logic       w_p;
    logic       w_np;
    logic [2:0] w_si;
    pkt_t       w_di [3];
    logic [2:0] w_so;
    logic [2:0] w_hz;
    logic       w_pe_dir;
    logic [2:0] w_req_cwo;
    logic [2:0] w_req_ccwo;
    logic [2:0] w_req_peo;
    logic [2:0] w_gnt_cwo;
    logic [2:0] w_gnt_ccwo;
    logic [2:0] w_gnt_peo;
    logic [2:0] w_clr;
    pkt_t       w_sel_cwo;
    pkt_t       w_sel_ccwo;
    pkt_t       w_sel_peo;

    assign w_p      = r_pol;
    assign w_np     = ~r_pol;
    assign polarity = r_pol;

    assign w_si[CW]  = cwsi;
    assign w_si[CCW] = ccwsi;
    assign w_si[PE]  = pesi;
    assign w_di[CW]  = cwdi;
    assign w_di[CCW] = ccwdi;
    assign w_di[PE]  = pedi;

    // External phase: link handshakes use the VC opposite to polarity
    assign cwri  = ~r_ib_full[CW][w_np];
    assign ccwri = ~r_ib_full[CCW][w_np];
    assign peri  = ~r_ib_full[PE][w_np];

    assign w_so[CW]  = r_ob_full[CW][w_np]  & cwro;
    assign w_so[CCW] = r_ob_full[CCW][w_np] & ccwro;
    assign w_so[PE]  = r_ob_full[PE][w_np]  & pero;

    assign cwso  = w_so[CW];
    assign ccwso = w_so[CCW];
    assign peso  = w_so[PE];
    assign cwdo  = w_so[CW]  ? r_ob_data[CW][w_np]  : '0;
    assign ccwdo = w_so[CCW] ? r_ob_data[CCW][w_np] : '0;
    assign pedo  = w_so[PE]  ? r_ob_data[PE][w_np]  : '0;

    // Internal phase: routing decision for the polarity VC of each input
    assign w_hz[CW]  = (r_ib_data[CW][w_p][HOP_MSB:HOP_LSB]  == 8'd0);
    assign w_hz[CCW] = (r_ib_data[CCW][w_p][HOP_MSB:HOP_LSB] == 8'd0);
    assign w_hz[PE]  = (r_ib_data[PE][w_p][HOP_MSB:HOP_LSB]  == 8'd0);
    assign w_pe_dir  = r_ib_data[PE][w_p][DIR_BIT];

    // Build per-output request vectors; ring inputs keep their direction
    always_comb begin
        w_req_cwo       = '0;
        w_req_ccwo      = '0;
        w_req_peo       = '0;
        w_req_cwo[CW]   = r_ib_full[CW][w_p]  & ~w_hz[CW];
        w_req_cwo[PE]   = r_ib_full[PE][w_p]  & ~w_hz[PE] & ~w_pe_dir;
        w_req_ccwo[CCW] = r_ib_full[CCW][w_p] & ~w_hz[CCW];
        w_req_ccwo[PE]  = r_ib_full[PE][w_p]  & ~w_hz[PE] &  w_pe_dir;
        w_req_peo[CW]   = r_ib_full[CW][w_p]  &  w_hz[CW];
        w_req_peo[CCW]  = r_ib_full[CCW][w_p] &  w_hz[CCW];
        w_req_peo[PE]   = r_ib_full[PE][w_p]  &  w_hz[PE];
    end

    rr_arb3 u_arb_cwo (
        .clk   (clk),
        .reset (reset),
        .i_en  (~r_ob_full[CW][w_p]),
        .i_req (w_req_cwo),
        .o_gnt (w_gnt_cwo)
    );

    rr_arb3 u_arb_ccwo (
        .clk   (clk),
        .reset (reset),
        .i_en  (~r_ob_full[CCW][w_p]),
        .i_req (w_req_ccwo),
        .o_gnt (w_gnt_ccwo)
    );

    rr_arb3 u_arb_peo (
        .clk   (clk),
        .reset (reset),
        .i_en  (~r_ob_full[PE][w_p]),
        .i_req (w_req_peo),
        .o_gnt (w_gnt_peo)
    );

    // Each input requests at most one output, so the OR of grants is its clear
    assign w_clr = w_gnt_cwo | w_gnt_ccwo | w_gnt_peo;

    assign w_sel_cwo  = w_gnt_cwo[CW]   ? r_ib_data[CW][w_p]  : r_ib_data[PE][w_p];
    assign w_sel_ccwo = w_gnt_ccwo[CCW] ? r_ib_data[CCW][w_p] : r_ib_data[PE][w_p];
    assign w_sel_peo  = w_gnt_peo[CW]   ? r_ib_data[CW][w_p]  :
                        w_gnt_peo[CCW]  ? r_ib_data[CCW][w_p] : r_ib_data[PE][w_p];

    // Buffer state: link fills/drains on VC ~p, internal moves on VC p
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pol <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_ib_full[2'(i)] <= '0;
                r_ob_full[2'(i)] <= '0;
            end
        end else begin
            r_pol <= ~r_pol;
            for (int unsigned i = 0; i < 3; i++) begin
                if (w_si[2'(i)] && !r_ib_full[2'(i)][w_np]) begin
                    r_ib_full[2'(i)][w_np] <= 1'b1;
                    r_ib_data[2'(i)][w_np] <= w_di[2'(i)];
                end
                if (w_clr[2'(i)]) begin
                    r_ib_full[2'(i)][w_p] <= 1'b0;
                end
                if (w_so[2'(i)]) begin
                    r_ob_full[2'(i)][w_np] <= 1'b0;
                end
            end
            if (|w_gnt_cwo) begin
                r_ob_full[CW][w_p] <= 1'b1;
                r_ob_data[CW][w_p] <= hop_dec(w_sel_cwo);
            end
            if (|w_gnt_ccwo) begin
                r_ob_full[CCW][w_p] <= 1'b1;
                r_ob_data[CCW][w_p] <= hop_dec(w_sel_ccwo);
            end
            if (|w_gnt_peo) begin
                r_ob_full[PE][w_p] <= 1'b1;
                r_ob_data[PE][w_p] <= w_sel_peo;
            end
        end
    end

endmodule

// File: tb/tb_ring_router_node.sv
// Directed bench for ring_router_node: single-packet routing table plus
// arbitration, back-pressure and reset-flush sequences.
module tb_ring_router_node;
    import ring_router_pkg::*;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        cwsi, ccwsi, pesi;
    logic        cwri, ccwri, peri;
    logic [0:63] cwdi, ccwdi, pedi;
    logic        cwso, ccwso, peso;
    logic        cwro, ccwro, pero;
    logic [0:63] cwdo, ccwdo, pedo;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        port_e       link;
        logic        pol;
        logic [0:63] pkt;
        port_e       out;
        logic [2:0]  exp_so;
        logic [0:63] exp;
    } vec_t;

    vec_t vecs [8];

    ring_router_node dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .cwsi     (cwsi),
        .ccwsi    (ccwsi),
        .pesi     (pesi),
        .cwri     (cwri),
        .ccwri    (ccwri),
        .peri     (peri),
        .cwdi     (cwdi),
        .ccwdi    (ccwdi),
        .pedi     (pedi),
        .cwso     (cwso),
        .ccwso    (ccwso),
        .peso     (peso),
        .cwro     (cwro),
        .ccwro    (ccwro),
        .pero     (pero),
        .cwdo     (cwdo),
        .ccwdo    (ccwdo),
        .pedo     (pedo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [0:63] mk(input logic vc, input logic dir, input logic [7:0] hop,
                                       input logic [15:0] mid, input logic [31:0] pay);
        logic [0:63] p;
        p                  = '0;
        p[VC_BIT]          = vc;
        p[DIR_BIT]         = dir;
        p[2:7]             = 6'b101101;
        p[HOP_MSB:HOP_LSB] = hop;
        p[16:31]           = mid;
        p[32:63]           = pay;
        return p;
    endfunction

    function automatic logic [2:0] so3();
        return {cwso, ccwso, peso};
    endfunction

    function automatic logic [2:0] ri3();
        return {cwri, ccwri, peri};
    endfunction

    function automatic logic [0:63] get_do(input port_e o);
        case (o)
            CW:      return cwdo;
            CCW:     return ccwdo;
            default: return pedo;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;
        cwdi = '0;   ccwdi = '0;   pedi = '0;
    endtask

    task automatic send(input port_e link, input logic [0:63] pkt);
        case (link)
            CW:      begin cwsi  = 1'b1; cwdi  = pkt; end
            CCW:     begin ccwsi = 1'b1; ccwdi = pkt; end
            default: begin pesi  = 1'b1; pedi  = pkt; end
        endcase
    endtask

    // Leaves the bench at the first negedge after reset (polarity 0), inputs idle
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        cwro = 1'b1; ccwro = 1'b1; pero = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [0:63] pa, pb, pc, p1, p2, p3, px, py, pz;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        cwro = 1'b1; ccwro = 1'b1; pero = 1'b1;
        idle_inputs();

        vecs[0] = '{PE,  1'b0, mk(1,0,8'd3,16'h1111,32'hDEADBEEF), CW,  3'b100, mk(1,0,8'd2,16'h1111,32'hDEADBEEF)};
        vecs[1] = '{CW,  1'b1, mk(0,0,8'd0,16'h2222,32'h0BADF00D), PE,  3'b001, mk(0,0,8'd0,16'h2222,32'h0BADF00D)};
        vecs[2] = '{CW,  1'b0, mk(1,1,8'd5,16'h3333,32'h12345678), CW,  3'b100, mk(1,1,8'd4,16'h3333,32'h12345678)};
        vecs[3] = '{CCW, 1'b1, mk(0,1,8'd1,16'h4444,32'h9ABCDEF0), CCW, 3'b010, mk(0,1,8'd0,16'h4444,32'h9ABCDEF0)};
        vecs[4] = '{CCW, 1'b0, mk(1,0,8'd0,16'h5555,32'hCAFEF00D), PE,  3'b001, mk(1,0,8'd0,16'h5555,32'hCAFEF00D)};
        vecs[5] = '{PE,  1'b1, mk(0,1,8'hFF,16'h6666,32'hFFFFFFFF), CCW, 3'b010, mk(0,1,8'hFE,16'h6666,32'hFFFFFFFF)};
        vecs[6] = '{PE,  1'b0, mk(1,1,8'd0,16'h7777,32'h00000001), PE,  3'b001, mk(1,1,8'd0,16'h7777,32'h00000001)};
        vecs[7] = '{CW,  1'b1, mk(0,1,8'd1,16'h8888,32'h55AA55AA), CW,  3'b100, mk(0,1,8'd0,16'h8888,32'h55AA55AA)};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: polarity alternates from 0, links quiet
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("idle%0d_pol", k), 64'(polarity), 64'(k % 2));
            check($sformatf("idle%0d_ri", k), 64'(ri3()), 64'(3'b111));
            check($sformatf("idle%0d_so", k), 64'(so3()), 64'(3'b000));
            check($sformatf("idle%0d_do", k), cwdo | ccwdo | pedo, 64'h0);
            @(negedge clk);
        end

        // Single-packet routing table: strobe appears exactly two cycles after injection
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 2 && polarity !== vecs[v].pol; k++) @(negedge clk);
            check($sformatf("v%0d_pol_align", v), 64'(polarity), 64'(vecs[v].pol));
            send(vecs[v].link, vecs[v].pkt);
            @(negedge clk);
            idle_inputs();
            #1;
            check($sformatf("v%0d_so_early", v), 64'(so3()), 64'(3'b000));
            @(negedge clk);
            #1;
            check($sformatf("v%0d_so", v), 64'(so3()), 64'(vecs[v].exp_so));
            check($sformatf("v%0d_do", v), get_do(vecs[v].out), vecs[v].exp);
            @(negedge clk);
            #1;
            check($sformatf("v%0d_so_after", v), 64'(so3()), 64'(3'b000));
            @(negedge clk);
        end

        // Round-robin on cwo: cw wins first, then pe beats a newly arrived cw
        do_reset();
        pa = mk(1,0,8'd2,16'hA0A0,32'h11112222);
        pb = mk(1,0,8'd1,16'hB0B0,32'h33334444);
        pc = mk(1,0,8'd3,16'hC0C0,32'h55556666);
        send(CW, pa);
        send(PE, pb);
        @(negedge clk); idle_inputs(); #1;
        check("arb_t1_so", 64'(cwso), 64'h0);
        @(negedge clk); send(CW, pc); #1;
        check("arb_t2_so", 64'(cwso), 64'h1);
        check("arb_t2_do", cwdo, mk(1,0,8'd1,16'hA0A0,32'h11112222));
        @(negedge clk); idle_inputs(); #1;
        check("arb_t3_so", 64'(cwso), 64'h0);
        @(negedge clk); #1;
        check("arb_t4_so", 64'(cwso), 64'h1);
        check("arb_t4_do", cwdo, mk(1,0,8'd0,16'hB0B0,32'h33334444));
        @(negedge clk); #1;
        check("arb_t5_so", 64'(cwso), 64'h0);
        @(negedge clk); #1;
        check("arb_t6_so", 64'(cwso), 64'h1);
        check("arb_t6_do", cwdo, mk(1,0,8'd2,16'hC0C0,32'h55556666));
        @(negedge clk); #1;
        check("arb_t7_so", 64'(so3()), 64'(3'b000));

        // Back-pressure on cwo: input fills, extra write dropped, order kept on release
        do_reset();
        cwro = 1'b0;
        p1 = mk(1,0,8'd2,16'hD1D1,32'hAAAA0001);
        p2 = mk(1,0,8'd4,16'hD2D2,32'hAAAA0002);
        p3 = mk(1,0,8'd6,16'hD3D3,32'hAAAA0003);
        send(CW, p1);
        @(negedge clk); idle_inputs(); #1;
        check("bp_t1_so", 64'(cwso), 64'h0);
        @(negedge clk); send(CW, p2); #1;
        check("bp_t2_so", 64'(cwso), 64'h0);
        check("bp_t2_ri", 64'(cwri), 64'h1);
        @(negedge clk); idle_inputs(); #1;
        check("bp_t3_so", 64'(cwso), 64'h0);
        @(negedge clk); send(CW, p3); #1;
        check("bp_t4_ri", 64'(cwri), 64'h0);
        check("bp_t4_so", 64'(cwso), 64'h0);
        @(negedge clk); idle_inputs(); #1;
        check("bp_t5_ri_vc0", 64'(cwri), 64'h1);
        @(negedge clk); cwro = 1'b1; #1;
        check("bp_t6_so", 64'(cwso), 64'h1);
        check("bp_t6_do", cwdo, mk(1,0,8'd1,16'hD1D1,32'hAAAA0001));
        check("bp_t6_ri", 64'(cwri), 64'h0);
        @(negedge clk); #1;
        check("bp_t7_so", 64'(cwso), 64'h0);
        @(negedge clk); #1;
        check("bp_t8_so", 64'(cwso), 64'h1);
        check("bp_t8_do", cwdo, mk(1,0,8'd3,16'hD2D2,32'hAAAA0002));
        check("bp_t8_ri", 64'(cwri), 64'h1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check($sformatf("bp_drop%0d_so", k), 64'(so3()), 64'(3'b000));
        end

        // Reset while packets are buffered discards them all
        do_reset();
        pero = 1'b0; ccwro = 1'b0;
        px = mk(1,0,8'd0,16'hE1E1,32'hBBBB0001);
        py = mk(1,0,8'd0,16'hE2E2,32'hBBBB0002);
        pz = mk(1,1,8'd2,16'hE3E3,32'hBBBB0003);
        send(PE, px);
        send(CW, py);
        send(CCW, pz);
        @(negedge clk); idle_inputs(); #1;
        check("fl_t1_so", 64'(so3()), 64'(3'b000));
        @(negedge clk); #1;
        check("fl_t2_ri", 64'(ri3()), 64'(3'b110));
        reset = 1'b1;
        cwro = 1'b1; ccwro = 1'b1; pero = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("fl_rst_so", 64'(so3()), 64'(3'b000));
        check("fl_rst_ri", 64'(ri3()), 64'(3'b111));
        check("fl_rst_pol", 64'(polarity), 64'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            check($sformatf("fl_post%0d_so", k), 64'(so3()), 64'(3'b000));
            check($sformatf("fl_post%0d_do", k), cwdo | ccwdo | pedo, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_router_node.md
# ring_router_node

Three-port, two-virtual-channel bidirectional ring router node. It sits directly between a processor NIC (PE port) and its clockwise and counter-clockwise ring neighbours. It accepts 64-bit packets on every input link and routes them by direction bit and hop count. It drives the global even/odd `polarity` that the NIC and neighbouring routers use to choose which virtual channel may cross external links in a given cycle.

## Interface
Parameters: none.

Ports (bit 0 = MSB on all buses):
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `polarity`  out  1  cycle parity; 0 after reset, toggles every cycle
- `cwsi`, `ccwsi`, `pesi`  in  1  send-in strobe per input link (cw, ccw, PE/NIC)
- `cwri`, `ccwri`, `peri`  out  1  ready-in per input link
- `cwdi`, `ccwdi`, `pedi`  in  64  packet in per input link
- `cwso`, `ccwso`, `peso`  out  1  send-out strobe per output link
- `cwro`, `ccwro`, `pero`  in  1  ready-out from downstream (neighbour ri / NIC ri)
- `cwdo`, `ccwdo`, `pedo`  out  64  packet out; 64'h0 when the matching so=0

## Operation
Packet fields:
- [0] vc
- [1] dir (0 = cw, 1 = ccw)
- [8:15] hop (unsigned links remaining)
- other bits opaque

Buffers:
- One 64-bit input buffer plus full flag per input link per VC (6 total).
- One 64-bit output buffer plus full flag per output link per VC (6 total).

Phases in each cycle with `polarity` = p:
- Internal phase moves VC p.
- External phase moves VC ~p.

External phase:
- `Xri` = !inbuf[X][~p].full.
- `Xsi`=1 writes `Xdi` into inbuf[X][~p] at the edge. The sender already respects ri; a write to a full buffer is a protocol error and is dropped.
- `Xso` = outbuf[X][~p].full & `Xro`. `Xdo` = that buffer. The buffer clears at the edge when `Xso`=1.

Internal phase, requests for each full inbuf[*][p]:
- cw/ccw input, hop≠0: request the output in the same direction (cw→cwo, ccw→ccwo).
- cw/ccw input, hop=0: request peo.
- PE input, hop≠0: request cwo if dir=0, ccwo if dir=1.
- PE input, hop=0: request peo (loopback).

Internal phase, grants:
- An output grants only if outbuf[out][p] is empty.
- Winner moves into outbuf[out][p] at the edge and its input buffer clears. Losers hold.
- Writes into cwo/ccwo store hop−1; all other fields are unchanged. Writes into peo are unchanged.
- Each output has a round-robin arbiter with priority order cw > ccw > pe at reset. After a grant, the winner becomes lowest priority; the pointer is unchanged when there is no grant.

Simultaneous events:
- A drain and a fill of the same buffer never coincide, because they belong to different phases.
- An input-buffer clear (internal, VC p) and a link write (external, VC ~p) touch different buffers, so both take effect.

Reset:
- All full flags=0, polarity=0, arbiter pointers reset.
- Resulting outputs: all ri=1, so=0, do=0.
- Packets in flight are discarded.

## Timing
- Packet written at edge E with vc=~p reaches its output buffer at edge E+1 (minimum), then is sent during the cycle after E+1 when ro=1.
- Minimum per-hop latency is 2 cycles, input strobe to output strobe.
- Every external transfer of VC v happens in a cycle with polarity=~v.
- The NIC drives vc=1 packets only when polarity=0, which matches this rule.
- ri/so are combinational from full flags, polarity, and ro. No combinational path from si to ri.

## Structure
- `ring_router_pkg`:
  - field constants: VC_BIT=0, DIR_BIT=1, HOP_MSB=8, HOP_LSB=15
  - port index enum: CW=0, CCW=1, PE=2
  - hop-decrement function
- Sub-module `rr_arb3`: 3-request round-robin arbiter with one-hot grant and pointer register. Instantiated for cwo, ccwo, peo; unused requests tied 0.

## Test plan
- Reset, then idle 4 cycles → polarity 0,1,0,1; all ri=1, all so=0, all do=0.
- pesi=1 at polarity 0 with vc=1, dir=0, hop=3, payload 0xDEADBEEF → cwso=1 two cycles later (polarity 0), hop=2, all other bits equal.
- cwsi with vc=0, hop=0 at polarity 1 → peso=1 two cycles later, pedo identical to input.
- Same-VC cwdi (hop 2) and pedi (dir 0, hop 1) pending together → cwo grants cw first with hop 1. PE is next with hop 0. The next cw arrival waits for PE (round-robin).
- Hold cwro=0 → cwo VC buffer stays full and cwso=0. Upstream feeds of that VC fill, dropping cwri, with no data lost. Raise cwro → packets drain in order.
- PE packet with hop 0 → loopback on peso. Assert reset while packets are buffered → next cycle all so=0, all ri=1, and nothing emerges afterwards.
